// File: rtl/guess_controller_if.sv
// Bundled port group between the Hangman game logic and guess_controller.
// HANGMAN_HINT_EN adds the hint_req/hint_used pair.
interface guess_controller_if #(
  parameter int WORD_LEN = 8
);
  logic                    word_load;
  logic [5*WORD_LEN-1:0]   word_in;
  logic [3:0]              word_len;
  logic                    in_game;
  logic                    guess_valid;
  logic [4:0]              guess_letter;
  logic                    guess_ready;
  logic [WORD_LEN-1:0]     revealed_mask;
  logic [3:0]              wrong_count;
  logic                    guess_hit;
  logic                    guess_miss;
  logic                    guess_dup;
  logic                    win_game;
  logic                    lost_game;
`ifdef HANGMAN_HINT_EN
  logic                    hint_req;
  logic                    hint_used;

  modport master (
    output word_load, word_in, word_len, in_game, guess_valid, guess_letter, hint_req,
    input  guess_ready, revealed_mask, wrong_count, guess_hit, guess_miss, guess_dup,
           win_game, lost_game, hint_used
  );
  modport slave (
    input  word_load, word_in, word_len, in_game, guess_valid, guess_letter, hint_req,
    output guess_ready, revealed_mask, wrong_count, guess_hit, guess_miss, guess_dup,
           win_game, lost_game, hint_used
  );
`else
  modport master (
    output word_load, word_in, word_len, in_game, guess_valid, guess_letter,
    input  guess_ready, revealed_mask, wrong_count, guess_hit, guess_miss, guess_dup,
           win_game, lost_game
  );
  modport slave (
    input  word_load, word_in, word_len, in_game, guess_valid, guess_letter,
    output guess_ready, revealed_mask, wrong_count, guess_hit, guess_miss, guess_dup,
           win_game, lost_game
  );
`endif
endinterface

// File: rtl/guess_controller.sv
// Per-round Hangman guess engine: scans the word one letter per cycle, tracks mask/wrong count.
// Optional HANGMAN_HINT_EN: hint_req reveals the lowest hidden letter at the cost of one wrong guess.
//
// state   | meaning
// IDLE    | waiting for a guess (or hint)
// SCAN    | comparing latched letter against word, one position per cycle
// RESOLVE | commit mask/count, emit exactly one result pulse
// END     | round won or lost; holds until word_load
module guess_controller #(
  parameter int WORD_LEN  = 8,
  parameter int MAX_WRONG = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  guess_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESOLVE, S_END} state_t;

  state_t                state_q, state_d;
  logic [5*WORD_LEN-1:0] word_q, word_d;
  logic [3:0]            len_q, len_d;
  logic [WORD_LEN-1:0]   mask_q, mask_d;
  logic [WORD_LEN-1:0]   scan_mask_q, scan_mask_d;
  logic [3:0]            count_q, count_d;
  logic [3:0]            idx_q, idx_d;
  logic [25:0]           guessed_q, guessed_d;
  logic [4:0]            letter_q, letter_d;
  logic                  found_q, found_d;
  logic                  dup_q, dup_d;
  logic                  hit_q, hit_d, miss_q, miss_d, dupo_q, dupo_d;
  logic                  win_q, win_d, lost_q, lost_d;
`ifdef HANGMAN_HINT_EN
  logic                  hint_q, hint_d;
  logic                  hint_used_q, hint_used_d;
  logic [4:0]            hint_letter;
`endif

  logic                  ready;
  logic                  is_dup;
  logic [WORD_LEN-1:0]   active;
  logic [WORD_LEN-1:0]   new_mask;
  logic [3:0]            new_count;
  logic                  new_win;

  always_comb begin
    for (int i = 0; i < WORD_LEN; i++) active[i] = (4'(i) < len_q);
  end

  assign ready     = (state_q == S_IDLE) & bus.in_game & ~win_q & ~lost_q;
  assign new_mask  = mask_q | scan_mask_q;
  assign new_win   = ((new_mask & active) == active);
  assign new_count = (count_q != 4'(MAX_WRONG)) ? count_q + 4'd1 : count_q;

  // Out-of-alphabet codes are treated like repeats: no scan, no penalty.
  always_comb begin
    is_dup = (bus.guess_letter >= 5'd26);
    for (int i = 0; i < 26; i++) begin
      if (bus.guess_letter == 5'(i) && guessed_q[i]) is_dup = 1'b1;
    end
  end

`ifdef HANGMAN_HINT_EN
  always_comb begin
    hint_letter = '0;
    for (int i = WORD_LEN - 1; i >= 0; i--) begin
      if (active[i] && !mask_q[i]) hint_letter = word_q[5*i +: 5];
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    len_d       = len_q;
    mask_d      = mask_q;
    scan_mask_d = scan_mask_q;
    count_d     = count_q;
    idx_d       = idx_q;
    guessed_d   = guessed_q;
    letter_d    = letter_q;
    found_d     = found_q;
    dup_d       = dup_q;
    win_d       = win_q;
    lost_d      = lost_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    dupo_d      = 1'b0;
`ifdef HANGMAN_HINT_EN
    hint_d      = hint_q;
    hint_used_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (ready && bus.guess_valid) begin
          letter_d    = bus.guess_letter;
          idx_d       = 4'd0;
          scan_mask_d = '0;
          found_d     = 1'b0;
          dup_d       = is_dup;
          state_d     = is_dup ? S_RESOLVE : S_SCAN;
`ifdef HANGMAN_HINT_EN
          hint_d      = 1'b0;
        end else if (ready && bus.hint_req) begin
          letter_d    = hint_letter;
          idx_d       = 4'd0;
          scan_mask_d = '0;
          found_d     = 1'b0;
          dup_d       = 1'b0;
          hint_d      = 1'b1;
          state_d     = S_SCAN;
`endif
        end
      end

      S_SCAN: begin
        for (int i = 0; i < WORD_LEN; i++) begin
          if (idx_q == 4'(i) && active[i] && word_q[5*i +: 5] == letter_q) begin
            scan_mask_d[i] = 1'b1;
            found_d        = 1'b1;
          end
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(WORD_LEN - 1)) state_d = S_RESOLVE;
      end

      S_RESOLVE: begin
        if (dup_q) begin
          dupo_d = 1'b1;
        end else begin
          for (int i = 0; i < 26; i++) begin
            if (letter_q == 5'(i)) guessed_d[i] = 1'b1;
          end
          mask_d = new_mask;
`ifdef HANGMAN_HINT_EN
          if (hint_q) begin
            count_d     = new_count;
            hint_used_d = 1'b1;
          end else
`endif
          if (found_q) begin
            hit_d = 1'b1;
          end else begin
            miss_d  = 1'b1;
            count_d = new_count;
          end
        end
        win_d   = ~dup_q & new_win;
        lost_d  = ~win_d & (count_d == 4'(MAX_WRONG));
        state_d = (win_d || lost_d) ? S_END : S_IDLE;
      end

      default: ;
    endcase

    // A new word overrides everything, including an in-flight guess.
    if (bus.word_load) begin
      word_d      = bus.word_in;
      if (bus.word_len == 4'd0)                 len_d = 4'd1;
      else if (bus.word_len > 4'(WORD_LEN))     len_d = 4'(WORD_LEN);
      else                                      len_d = bus.word_len;
      mask_d      = '0;
      scan_mask_d = '0;
      count_d     = 4'd0;
      idx_d       = 4'd0;
      guessed_d   = '0;
      found_d     = 1'b0;
      dup_d       = 1'b0;
      win_d       = 1'b0;
      lost_d      = 1'b0;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      dupo_d      = 1'b0;
`ifdef HANGMAN_HINT_EN
      hint_d      = 1'b0;
      hint_used_d = 1'b0;
`endif
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      len_q       <= 4'd1;
      mask_q      <= '0;
      scan_mask_q <= '0;
      count_q     <= 4'd0;
      idx_q       <= 4'd0;
      guessed_q   <= '0;
      letter_q    <= 5'd0;
      found_q     <= 1'b0;
      dup_q       <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      dupo_q      <= 1'b0;
      win_q       <= 1'b0;
      lost_q      <= 1'b0;
`ifdef HANGMAN_HINT_EN
      hint_q      <= 1'b0;
      hint_used_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      len_q       <= len_d;
      mask_q      <= mask_d;
      scan_mask_q <= scan_mask_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      guessed_q   <= guessed_d;
      letter_q    <= letter_d;
      found_q     <= found_d;
      dup_q       <= dup_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      dupo_q      <= dupo_d;
      win_q       <= win_d;
      lost_q      <= lost_d;
`ifdef HANGMAN_HINT_EN
      hint_q      <= hint_d;
      hint_used_q <= hint_used_d;
`endif
    end
  end

  assign bus.guess_ready   = ready;
  assign bus.revealed_mask = mask_q;
  assign bus.wrong_count   = count_q;
  assign bus.guess_hit     = hit_q;
  assign bus.guess_miss    = miss_q;
  assign bus.guess_dup     = dupo_q;
  assign bus.win_game      = win_q;
  assign bus.lost_game     = lost_q;
`ifdef HANGMAN_HINT_EN
  assign bus.hint_used     = hint_used_q;
`endif

endmodule

// File: tb/tb_guess_controller.sv
// Scoreboard bench for guess_controller: stimulus pushes expected results, a monitor pops on each pulse.
module tb_guess_controller;

  localparam int WL = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  guess_controller_if #(.WORD_LEN(WL)) bus ();

  guess_controller #(.WORD_LEN(WL), .MAX_WRONG(6)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] kind;   // {hint_used, dup, miss, hit}
    logic [7:0] mask;
    logic [3:0] count;
    logic       win;
    logic       lost;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  logic hint_used_s;
`ifdef HANGMAN_HINT_EN
  assign hint_used_s = bus.hint_used;
`else
  assign hint_used_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [3:0] k;
    exp_t e;
    k = {hint_used_s, bus.guess_dup, bus.guess_miss, bus.guess_hit};
    if (!rst && k != 4'b0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=%b required=none (cycle %0d)", k, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", int'(k), int'(e.kind));
        chk("mask", int'(bus.revealed_mask), int'(e.mask));
        chk("wrong_count", int'(bus.wrong_count), int'(e.count));
        chk("win_game", int'(bus.win_game), int'(e.win));
        chk("lost_game", int'(bus.lost_game), int'(e.lost));
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic [5*WL-1:0] mkw(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c);
    mkw = {25'd0, c, b, a};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.guess_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.guess_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic load_word(input logic [5*WL-1:0] w, input logic [3:0] len);
    @(negedge clk);
    bus.word_load = 1'b1;
    bus.word_in   = w;
    bus.word_len  = len;
    @(negedge clk);
    bus.word_load = 1'b0;
    #1;
  endtask

  task automatic do_guess(input logic [4:0] l, input logic [3:0] kind, input logic [7:0] m,
                          input logic [3:0] c, input logic w, input logic lo);
    exp_t e;
    int   lat;
    wait_ready();
    lat = (kind == 4'b0100) ? 1 : WL + 1;
    e.kind = kind; e.mask = m; e.count = c; e.win = w; e.lost = lo;
    e.cyc  = cyc + 1 + lat;
    sb.push_back(e);
    bus.guess_valid  = 1'b1;
    bus.guess_letter = l;
    @(negedge clk);
    bus.guess_valid  = 1'b0;
    #1;
    drain();
  endtask

  localparam logic [3:0] HIT = 4'b0001, MISS = 4'b0010, DUP = 4'b0100;

  initial begin
    cyc = 0; checks = 0; failures = 0;
    rst = 1'b1;
    bus.word_load = 1'b0; bus.word_in = '0; bus.word_len = 4'd0;
    bus.in_game = 1'b0; bus.guess_valid = 1'b0; bus.guess_letter = 5'd0;
`ifdef HANGMAN_HINT_EN
    bus.hint_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_mask", int'(bus.revealed_mask), 0);
    chk("rst_count", int'(bus.wrong_count), 0);
    chk("rst_pulses", int'({bus.guess_hit, bus.guess_miss, bus.guess_dup, hint_used_s}), 0);
    chk("rst_win_lost", int'({bus.win_game, bus.lost_game}), 0);
    chk("rst_ready", int'(bus.guess_ready), 0);
    rst = 1'b0;
    bus.in_game = 1'b1;

    // CAT, win path
    load_word(mkw(5'd2, 5'd0, 5'd19), 4'd3);
    chk("ready_after_load", int'(bus.guess_ready), 1);
    do_guess(5'd0,  HIT, 8'b0000_0010, 4'd0, 1'b0, 1'b0);
    do_guess(5'd2,  HIT, 8'b0000_0011, 4'd0, 1'b0, 1'b0);
    do_guess(5'd19, HIT, 8'b0000_0111, 4'd0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("win_ready", int'(bus.guess_ready), 0);
    chk("win_held", int'(bus.win_game), 1);

    // Six distinct absent letters lose the round
    load_word(mkw(5'd2, 5'd0, 5'd19), 4'd3);
    chk("load_clears_win", int'(bus.win_game), 0);
    for (int i = 0; i < 6; i++)
      do_guess(5'(25 - i), MISS, 8'h00, 4'(i + 1), 1'b0, (i == 5));
    chk("lost_ready", int'(bus.guess_ready), 0);
    bus.guess_valid = 1'b1; bus.guess_letter = 5'd18;
    repeat (12) @(negedge clk);
    bus.guess_valid = 1'b0;
    chk("lost_count_held", int'(bus.wrong_count), 6);
    chk("lost_held", int'(bus.lost_game), 1);

    // Repeats and out-of-range codes
    load_word(mkw(5'd2, 5'd0, 5'd19), 4'd3);
    do_guess(5'd0,  HIT, 8'b0000_0010, 4'd0, 1'b0, 1'b0);
    do_guess(5'd0,  DUP, 8'b0000_0010, 4'd0, 1'b0, 1'b0);
    do_guess(5'd30, DUP, 8'b0000_0010, 4'd0, 1'b0, 1'b0);

    // word_load during SCAN at idx 4 aborts without a pulse
    load_word(mkw(5'd2, 5'd0, 5'd19), 4'd3);
    do_guess(5'd0,  HIT,  8'b0000_0010, 4'd0, 1'b0, 1'b0);
    do_guess(5'd25, MISS, 8'b0000_0010, 4'd1, 1'b0, 1'b0);
    wait_ready();
    bus.guess_valid = 1'b1; bus.guess_letter = 5'd2;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.word_load = 1'b1;
    @(negedge clk);
    bus.word_load = 1'b0;
    #1;
    chk("abort_mask", int'(bus.revealed_mask), 0);
    chk("abort_count", int'(bus.wrong_count), 0);
    chk("abort_idle_ready", int'(bus.guess_ready), 1);
    repeat (12) @(negedge clk);
    do_guess(5'd0, HIT, 8'b0000_0010, 4'd0, 1'b0, 1'b0);

    // word_len 0 clamps to one active letter
    load_word(mkw(5'd2, 5'd0, 5'd19), 4'd0);
    do_guess(5'd2, HIT, 8'b0000_0001, 4'd0, 1'b1, 1'b0);

    // in_game falling mid-SCAN does not abort
    load_word(mkw(5'd2, 5'd0, 5'd19), 4'd3);
    begin
      exp_t e;
      wait_ready();
      e.kind = HIT; e.mask = 8'b0000_0100; e.count = 4'd0; e.win = 1'b0; e.lost = 1'b0;
      e.cyc = cyc + 1 + WL + 1;
      sb.push_back(e);
      bus.guess_valid = 1'b1; bus.guess_letter = 5'd19;
      @(negedge clk);
      bus.guess_valid = 1'b0;
      bus.in_game = 1'b0;
      drain();
      chk("ingame_low_ready", int'(bus.guess_ready), 0);
      bus.in_game = 1'b1;
      #1;
      chk("ingame_high_ready", int'(bus.guess_ready), 1);
    end

    // Asynchronous reset mid-SCAN
    wait_ready();
    bus.guess_valid = 1'b1; bus.guess_letter = 5'd2;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mask", int'(bus.revealed_mask), 0);
    chk("async_rst_flags", int'({bus.win_game, bus.lost_game, bus.guess_hit}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

`ifdef HANGMAN_HINT_EN
    // Hint on AAB reveals both A's for one wrong guess
    load_word(mkw(5'd0, 5'd0, 5'd1), 4'd3);
    begin
      exp_t e;
      wait_ready();
      e.kind = 4'b1000; e.mask = 8'b0000_0011; e.count = 4'd1; e.win = 1'b0; e.lost = 1'b0;
      e.cyc = cyc + 1 + WL + 1;
      sb.push_back(e);
      bus.hint_req = 1'b1;
      @(negedge clk);
      bus.hint_req = 1'b0;
      #1;
      drain();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
